// File: rtl/ept_xlate_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ept_xlate_queue
// Description : In-order request queue in front of a combinational EPT
//               translator. The head entry is presented to the EPT, and its
//               result is captured in a single response register together
//               with the requester tag.
// Revision    : 1.0 - initial release
// ============================================================================
module ept_xlate_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    // request side
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [7:0]                 req_vmid_i,
    input  logic [63:0]                req_gpa_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    // EPT side
    output logic                       translate_valid_o,
    output logic [7:0]                 vmid_o,
    output logic [63:0]                gpa_o,
    input  logic [63:0]                hpa_i,
    input  logic                       fault_i,
    // response side
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [63:0]                resp_hpa_o,
    output logic                       resp_fault_o,
    output logic [TAG_W-1:0]           resp_tag_o,
    // status
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int                 c_ptr_w     = $clog2(DEPTH);
    localparam int                 c_cnt_w     = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    // FIFO storage: deliberately not reset, only the pointers are
    logic [7:0]       r_mem_vmid [DEPTH];
    logic [63:0]      r_mem_gpa  [DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [DEPTH];

    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;

    logic             r_resp_valid;
    logic [63:0]      r_resp_hpa;
    logic             r_resp_fault;
    logic [TAG_W-1:0] r_resp_tag;

    logic w_empty;
    logic w_slot_free;
    logic w_push;
    logic w_pop;

    // Handshake decode: acceptance never looks at a same-cycle pop, and the
    // head only moves when the response register can take the result.
    assign w_empty     = (r_count == '0);
    assign w_slot_free = !r_resp_valid || resp_ready_i;
    assign req_ready_o = (r_count < c_depth_cnt) && !flush_i;
    assign w_push      = req_valid_i && req_ready_o;
    assign w_pop       = !w_empty && w_slot_free && !flush_i;

    assign translate_valid_o = w_pop;
    assign vmid_o            = w_empty ? 8'd0  : r_mem_vmid[r_rptr];
    assign gpa_o             = w_empty ? 64'd0 : r_mem_gpa[r_rptr];

    assign resp_valid_o = r_resp_valid;
    assign resp_hpa_o   = r_resp_hpa;
    assign resp_fault_o = r_resp_fault;
    assign resp_tag_o   = r_resp_tag;
    assign count_o      = r_count;

    // Write the accepted request into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_vmid[r_wptr] <= req_vmid_i;
            r_mem_gpa[r_wptr]  <= req_gpa_i;
            r_mem_tag[r_wptr]  <= req_tag_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush behaves like a soft reset
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response register: load on pop, drop on consume, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_hpa   <= '0;
            r_resp_fault <= 1'b0;
            r_resp_tag   <= '0;
        end else if (flush_i) begin
            r_resp_valid <= 1'b0;
        end else if (w_pop) begin
            r_resp_valid <= 1'b1;
            r_resp_hpa   <= hpa_i;
            r_resp_fault <= fault_i;
            r_resp_tag   <= r_mem_tag[r_rptr];
        end else if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ept_xlate_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ept_xlate_queue
// Description : Scoreboard bench for ept_xlate_queue with a combinational EPT
//               model (hpa = gpa ^ 0xFF, fault when vmid = 0xFF).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ept_xlate_queue;

    localparam int c_depth = 4;
    localparam int c_tag_w = 4;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         flush_i;
    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [7:0]                   req_vmid_i;
    logic [63:0]                  req_gpa_i;
    logic [c_tag_w-1:0]           req_tag_i;
    logic                         translate_valid_o;
    logic [7:0]                   vmid_o;
    logic [63:0]                  gpa_o;
    logic [63:0]                  hpa_i;
    logic                         fault_i;
    logic                         resp_valid_o;
    logic                         resp_ready_i;
    logic [63:0]                  resp_hpa_o;
    logic                         resp_fault_o;
    logic [c_tag_w-1:0]           resp_tag_o;
    logic [$clog2(c_depth+1)-1:0] count_o;

    typedef struct packed {
        logic [63:0]        hpa;
        logic               fault;
        logic [c_tag_w-1:0] tag;
    } resp_t;

    resp_t sb[$];
    int    hs_cyc[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    resp_t held;

    ept_xlate_queue #(.DEPTH(c_depth), .TAG_W(c_tag_w)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_vmid_i        (req_vmid_i),
        .req_gpa_i         (req_gpa_i),
        .req_tag_i         (req_tag_i),
        .translate_valid_o (translate_valid_o),
        .vmid_o            (vmid_o),
        .gpa_o             (gpa_o),
        .hpa_i             (hpa_i),
        .fault_i           (fault_i),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .resp_hpa_o        (resp_hpa_o),
        .resp_fault_o      (resp_fault_o),
        .resp_tag_o        (resp_tag_o),
        .count_o           (count_o)
    );

    // Combinational EPT model
    assign hpa_i   = gpa_o ^ 64'hFF;
    assign fault_i = (vmid_o == 8'hFF);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic resp_t model(input logic [7:0] v, input logic [63:0] g,
                                    input logic [c_tag_w-1:0] t);
        resp_t m;
        m.hpa   = g ^ 64'hFF;
        m.fault = (v == 8'hFF);
        m.tag   = t;
        return m;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is compared against the scoreboard
    always @(negedge clk) begin : mon
        resp_t got;
        resp_t exp_r;
        if (rst_n && !flush_i && resp_valid_o && resp_ready_i) begin
            got = '{hpa: resp_hpa_o, fault: resp_fault_o, tag: resp_tag_o};
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got %0h required none", got);
            end else begin
                exp_r = sb.pop_front();
                check("resp", 128'(got), 128'(exp_r));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request; expected response is queued once acceptance is seen
    task automatic push(input logic [7:0] v, input logic [63:0] g, input logic [c_tag_w-1:0] t);
        int tries = 0;
        req_valid_i = 1'b1;
        req_vmid_i  = v;
        req_gpa_i   = g;
        req_tag_i   = t;
        forever begin
            @(negedge clk);
            if (req_ready_o) begin
                sb.push_back(model(v, g, t));
                tick();
                break;
            end
            tick();
            tries++;
            if (tries > 50) begin
                check("push_timeout", 1'b0, 1'b1);
                break;
            end
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (count_o == 0 && !resp_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 1'b0;
        req_vmid_i   = '0;
        req_gpa_i    = '0;
        req_tag_i    = '0;
        resp_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_count", count_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_resp_hpa", resp_hpa_o, 0);
        check("rst_resp_fault", resp_fault_o, 0);
        check("rst_resp_tag", resp_tag_o, 0);
        check("rst_tv", translate_valid_o, 0);
        check("rst_gpa_o", gpa_o, 0);
        check("rst_ready", req_ready_o, 1);
        tick();
        rst_n        = 1'b1;
        resp_ready_i = 1'b1;

        // Single request, two-cycle latency
        push(8'd3, 64'h1000, 4'd5);
        @(negedge clk);
        check("t1_tv", translate_valid_o, 1);
        check("t1_vmid", vmid_o, 8'd3);
        check("t1_gpa", gpa_o, 64'h1000);
        check("t1_rv_early", resp_valid_o, 0);
        @(negedge clk);
        check("t1_rv", resp_valid_o, 1);
        check("t1_hpa", resp_hpa_o, 64'h10FF);
        check("t1_tag", resp_tag_o, 4'd5);
        check("t1_fault", resp_fault_o, 0);
        wait_idle("t1_idle");

        // Full queue and backpressure
        resp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            push(8'h10 + 8'(i), 64'h2000 + 64'(i * 16), 4'(i + 1));
        req_valid_i = 1'b1;
        req_vmid_i  = 8'h20;
        req_gpa_i   = 64'h3000;
        req_tag_i   = 4'd6;
        @(negedge clk);
        check("full_count", count_o, 4);
        check("full_ready", req_ready_o, 0);
        check("full_rv", resp_valid_o, 1);
        check("full_tv", translate_valid_o, 0);
        check("full_held_hpa", resp_hpa_o, 64'h20FF);
        held = '{hpa: resp_hpa_o, fault: resp_fault_o, tag: resp_tag_o};
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check("bp_payload", 128'({resp_hpa_o, resp_fault_o, resp_tag_o}), 128'(held));
            check("bp_rv", resp_valid_o, 1);
            check("bp_tv", translate_valid_o, 0);
            check("bp_ready", req_ready_o, 0);
        end
        tick();
        resp_ready_i = 1'b1;
        @(negedge clk);
        check("release_ready", req_ready_o, 0);
        check("release_tv", translate_valid_o, 1);
        tick();
        push(8'h20, 64'h3000, 4'd6);
        wait_idle("t2_idle");

        // Streaming: one response per cycle
        hs_cyc.delete();
        for (int i = 0; i < 8; i++)
            push((i == 5) ? 8'hFF : 8'h40 + 8'(i), 64'h5000 + 64'(i * 256), 4'(i));
        wait_idle("t3_idle");
        check("stream_n", hs_cyc.size(), 8);
        for (int i = 1; i < 8 && i < hs_cyc.size(); i++)
            check("stream_gap", hs_cyc[i] - hs_cyc[i-1], 1);

        // Flush with 1 held and 3 queued
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push(8'h60 + 8'(i), 64'h6000 + 64'(i * 16), 4'(8 + i));
        @(negedge clk);
        check("fl_pre_count", count_o, 3);
        check("fl_pre_rv", resp_valid_o, 1);
        tick();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_vmid_i  = 8'h77;
        req_gpa_i   = 64'h7700;
        req_tag_i   = 4'd7;
        @(negedge clk);
        check("fl_ready", req_ready_o, 0);
        check("fl_tv", translate_valid_o, 0);
        tick();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check("fl_count", count_o, 0);
        check("fl_rv", resp_valid_o, 0);
        tick();
        resp_ready_i = 1'b1;
        push(8'h61, 64'h7000, 4'hE);
        wait_idle("fl_idle");

        // Mid-stream reset with 1 held and 2 queued
        resp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            push(8'h80 + 8'(i), 64'h8000 + 64'(i * 16), 4'(i + 2));
        rst_n = 1'b0;
        tick();
        sb.delete();
        @(negedge clk);
        check("rs_count", count_o, 0);
        check("rs_rv", resp_valid_o, 0);
        check("rs_hpa", resp_hpa_o, 0);
        check("rs_fault", resp_fault_o, 0);
        check("rs_tag", resp_tag_o, 0);
        check("rs_tv", translate_valid_o, 0);
        check("rs_vmid", vmid_o, 0);
        check("rs_gpa", gpa_o, 0);
        tick();
        rst_n        = 1'b1;
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_vmid_i   = 8'h90;
        req_gpa_i    = 64'h9000;
        req_tag_i    = 4'hA;
        @(negedge clk);
        check("rs_first_ready", req_ready_o, 1);
        if (req_ready_o) sb.push_back(model(8'h90, 64'h9000, 4'hA));
        tick();
        req_valid_i = 1'b0;
        wait_idle("rs_idle");
        repeat (5) tick();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
